// File: rtl/bidir_parity_responder.sv
// Responder end of a single-wire half-duplex link: samples start/data/parity frames
// on io, checks even parity, drives ACK/NAK back, and holds accepted words for the core.
module bidir_parity_responder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire               io,
    output logic              oe,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              par_err,
    output logic              ovr_err,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_TURN, S_ACK} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              ack_bit;
    logic              line;
    logic              par_ok;
    logic              slot_free;
    logic              load;
    logic              err_evt;

    // oe and ack_bit are both flops, so the pad never loops io back onto itself.
    assign io   = oe ? ack_bit : 1'bz;
    assign line = io;
    assign busy = (state != S_IDLE);

    assign par_ok    = ~(par_acc ^ line);
    assign slot_free = !rx_valid || rx_ready;
    assign load      = (state == S_PARITY) && par_ok && slot_free;
    assign err_evt   = (state == S_PARITY) && !(par_ok && slot_free);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (line == 1'b0) state_nx = S_DATA;
            S_DATA:   if (cnt == LAST) state_nx = S_PARITY;
            S_PARITY: state_nx = S_TURN;
            S_TURN:   state_nx = S_ACK;
            S_ACK:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            ack_bit  <= 1'b0;
            oe       <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            par_err  <= 1'b0;
            ovr_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state   <= state_nx;
            oe      <= (state_nx == S_ACK);
            par_err <= 1'b0;
            ovr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    par_acc <= 1'b0;
                end
                S_DATA: begin
                    shreg[cnt] <= line;
                    par_acc    <= par_acc ^ line;
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                S_PARITY: begin
                    // A bad-parity frame reports only par_err, even when the slot is full.
                    if (!par_ok) begin
                        ack_bit <= 1'b1;
                        par_err <= 1'b1;
                    end else if (slot_free) begin
                        ack_bit <= 1'b0;
                    end else begin
                        ack_bit <= 1'b1;
                        ovr_err <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bidir_parity_responder.sv
// Scoreboard bench: the driver predicts ACK/NAK, accepted words and error kinds per frame,
// and a negedge monitor pops and compares them as the responder presents them.
module tb_bidir_parity_responder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         oe, busy, rx_valid, par_err, ovr_err;
    logic         rx_ready = 1'b0;
    logic [W-1:0] rx_data;
    logic [7:0]   err_cnt;
    wire          io;

    logic tb_drv = 1'b1;
    logic tb_bit = 1'b1;
    assign io = tb_drv ? tb_bit : 1'bz;
    pullup (io);

    bidir_parity_responder #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .io(io), .oe(oe), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .par_err(par_err), .ovr_err(ovr_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_words[$];
    logic         exp_acks[$];
    logic [1:0]   exp_err[$];   // {ovr, par}

    bit  mdl_full = 0;
    bit  load_now = 0;
    int  mdl_errs = 0;
    bit  rnd_rdy  = 0;
    logic         pre_rv, post_rv;
    logic [W-1:0] post_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_cnt();
        return (mdl_errs > 255) ? 8'd255 : 8'(mdl_errs);
    endfunction

    // Monitor: every handshake, ACK cycle and error pulse must match the next prediction.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            checks++;
            if (exp_words.size() == 0) begin
                errors++;
                $display("FAIL word: unexpected handshake data %0h", rx_data);
            end else begin
                logic [W-1:0] w;
                w = exp_words.pop_front();
                if (rx_data !== w) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", rx_data, w);
                end
            end
        end
        if (oe === 1'b1) begin
            checks++;
            if (exp_acks.size() == 0) begin
                errors++;
                $display("FAIL ack: unexpected drive io=%b", io);
            end else begin
                logic a;
                a = exp_acks.pop_front();
                if (io !== a) begin
                    errors++;
                    $display("FAIL ack: got io=%b expected %b", io, a);
                end
            end
        end
        if (par_err === 1'b1 || ovr_err === 1'b1) begin
            checks++;
            if (exp_err.size() == 0) begin
                errors++;
                $display("FAIL errpulse: unexpected ovr=%b par=%b", ovr_err, par_err);
            end else begin
                logic [1:0] e;
                e = exp_err.pop_front();
                if ({ovr_err, par_err} !== e) begin
                    errors++;
                    $display("FAIL errpulse: got %b expected %b", {ovr_err, par_err}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (!rst_n)              mdl_full = 0;
        else if (load_now)       mdl_full = 1;
        else if (mdl_full && rx_ready) mdl_full = 0;
        load_now = 0;
        #1;
        if (rnd_rdy) rx_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic reset_edge(input string tag);
        rst_n = 1'b0;
        step();
        exp_words.delete();
        mdl_full = 0;
        mdl_errs = 0;
        chk({tag, "_oe"},    32'(oe), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_valid"}, 32'(rx_valid), 0);
        rst_n = 1'b1;
        tb_drv = 1'b1;
        tb_bit = 1'b1;
    endtask

    // abort_bit >= 0: reset while that data bit is on the line; par_rdy >= 0 forces rx_ready on the parity edge.
    task automatic send_frame(input logic [W-1:0] d, input logic p, input int abort_bit,
                              input bit abort_ack, input int par_rdy);
        bit good, free;
        tb_drv = 1'b1;
        tb_bit = 1'b0;
        step();
        for (int i = 0; i < W; i++) begin
            tb_bit = d[i];
            if (i == abort_bit) begin
                reset_edge("rst_data");
                return;
            end
            step();
        end
        tb_bit = p;
        if (par_rdy >= 0) rx_ready = par_rdy[0];
        good = (($countones(d) % 2) == int'(p));
        free = !mdl_full || rx_ready;
        exp_acks.push_back(!(good && free));
        if (good && free) begin
            exp_words.push_back(d);
            load_now = 1;
        end else begin
            mdl_errs++;
            exp_err.push_back(good ? 2'b10 : 2'b01);
        end
        pre_rv = rx_valid;
        step();
        post_rv = rx_valid;
        post_data = rx_data;
        if (par_rdy >= 0) rx_ready = 1'b0;
        tb_drv = 1'b0;
        step();
        if (abort_ack) begin
            reset_edge("rst_ack");
            return;
        end
        step();
        tb_drv = 1'b1;
        tb_bit = 1'b1;
        chk("end_busy", 32'(busy), 0);
        chk("end_oe", 32'(oe), 0);
        chk("end_errcnt", 32'(err_cnt), 32'(exp_cnt()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        step();
        reset_edge("reset");
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_perr", 32'(par_err), 0);
        chk("reset_oerr", 32'(ovr_err), 0);
        chk("reset_cnt",  32'(err_cnt), 0);
        chk("idle_line",  32'(io), 1);
        idle(2);

        // Good frame, latency check: valid only appears on the 9th edge after start.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b0, -1, 0, -1);
        chk("a5_pre_valid", 32'(pre_rv), 0);
        chk("a5_post_valid", 32'(post_rv), 1);
        chk("a5_data", 32'(post_data), 32'hA5);
        idle(2);

        // Bad parity.
        send_frame(8'h01, 1'b0, -1, 0, -1);
        chk("bad_valid", 32'(post_rv), 0);
        chk("bad_cnt", 32'(err_cnt), 1);
        idle(2);

        // Overrun with the core stalled.
        reset_edge("rst2");
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, -1, 0, -1);
        idle(2);
        send_frame(8'h0F, 1'b0, -1, 0, -1);
        chk("ovr_data", 32'(rx_data), 32'h3C);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_cnt", 32'(err_cnt), 1);
        idle(2);

        // Core frees the slot on the very parity edge.
        reset_edge("rst3");
        send_frame(8'h3C, 1'b0, -1, 0, -1);
        idle(2);
        send_frame(8'h0F, 1'b0, -1, 0, 1);
        chk("swap_data", 32'(rx_data), 32'h0F);
        chk("swap_valid", 32'(rx_valid), 1);
        chk("swap_cnt", 32'(err_cnt), 0);
        idle(2);

        // Reset mid-data then during ACK, each followed by a clean frame.
        send_frame(8'h77, 1'b0, 3, 0, -1);
        idle(2);
        send_frame(8'h55, 1'b0, -1, 0, -1);
        chk("after_rst_data", 32'(rx_data), 32'h55);
        chk("after_rst_valid", 32'(rx_valid), 1);
        idle(2);
        send_frame(8'h81, 1'b0, -1, 1, -1);
        idle(2);
        send_frame(8'h55, 1'b0, -1, 0, -1);
        chk("after_ack_rst_data", 32'(rx_data), 32'h55);
        idle(2);

        // Randomised frames with a randomly stalling core.
        rnd_rdy = 1;
        for (int f = 0; f < 60; f++) begin
            logic [W-1:0] d;
            logic p;
            d = W'($urandom);
            p = 1'(($countones(d) % 2) ^ ($urandom_range(0, 3) == 0));
            send_frame(d, p, -1, 0, -1);
            idle($urandom_range(1, 3));
        end

        // Saturate the error counter.
        for (int f = 0; f < 260; f++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            send_frame(d, 1'(~($countones(d) % 2)), -1, 0, -1);
            idle(1);
        end
        chk("sat_cnt", 32'(err_cnt), 255);

        rnd_rdy = 0;
        rx_ready = 1'b1;
        idle(3);
        chk("drain_valid", 32'(rx_valid), 0);
        chk("left_words", 32'(exp_words.size()), 0);
        chk("left_acks",  32'(exp_acks.size()), 0);
        chk("left_errs",  32'(exp_err.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
